// File: rtl/stage_fetch.sv
// -----------------------------------------------------------------------------
// stage_fetch
//
// Pipeline front end. Owns the PC, issues in-order word reads to instruction
// memory over a req/gnt/rvalid handshake, buffers returned words and hands one
// instruction per cycle to decode. Honours decode backpressure (stall) and PC
// redirects from execute, discarding wrong-path words both buffered and still
// in flight.
//
// Parameters
//   RESET_PC  PC value after reset.
//   DEPTH     Maximum words in flight plus buffered (must be >= 2).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   imem_req / imem_addr     read request and word-aligned address
//   imem_gnt                 request accepted this cycle
//   imem_rvalid / imem_rdata in-order read response
//   redirect / redirect_addr replace the PC, kill wrong-path words
//   stall                    decode cannot accept; hold outputs
//   instr                    registered instruction to decode
//   fetch_instr_addr         address of instr
//   fetch_instr_addr_plus    fetch_instr_addr + 4 (mod 2^32)
//   fetch_valid              instr is a real fetched word
// -----------------------------------------------------------------------------
module stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [31:0] fetch_instr_addr,
    output logic [31:0] fetch_instr_addr_plus,
    output logic        fetch_valid
);

    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam logic [31:0]   NOP      = 32'h0000_0013;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] kill_q, kill_d;
    logic [CW-1:0] count_q, count_d;

    // Addresses of granted requests, popped by every response (live or killed).
    logic [31:0]   aq_mem [DEPTH];
    logic [PW-1:0] aq_wr_q, aq_rd_q;

    // Returned words waiting for decode.
    logic [31:0]   buf_addr [DEPTH];
    logic [31:0]   buf_data [DEPTH];
    logic [PW-1:0] buf_wr_q, buf_wr_d;
    logic [PW-1:0] buf_rd_q, buf_rd_d;

    logic [31:0]   instr_q, instr_d;
    logic [31:0]   faddr_q, faddr_d;
    logic [31:0]   fplus_q, fplus_d;
    logic          valid_q, valid_d;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic        grant;
    logic        resp_live;
    logic        resp_kill;
    logic [31:0] resp_addr;
    logic        buf_empty;
    logic        bypass;
    logic        buf_push;
    logic        buf_pop;
    logic [CW:0] credits_used;

    // Only the word-aligned part of the redirect target is meaningful.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_addr[1:0];

    assign credits_used = {1'b0, inflight_q} + {1'b0, count_q};

    // Credit check keeps buffered + in-flight words within DEPTH so the buffer
    // can always absorb every outstanding response, even under a long stall.
    assign imem_req  = !rst && !redirect && (credits_used < {1'b0, DEPTH_C});
    assign imem_addr = pc_q;

    assign grant     = imem_req && imem_gnt;
    assign resp_live = imem_rvalid && (kill_q == '0);
    assign resp_kill = imem_rvalid && (kill_q != '0);
    assign resp_addr = aq_mem[aq_rd_q];
    assign buf_empty = (count_q == '0);

    // A live response goes straight to the output registers only when nothing
    // older is buffered and decode will take it this cycle.
    assign bypass    = resp_live && buf_empty && !stall && !redirect;
    assign buf_push  = resp_live && !redirect && !bypass;
    assign buf_pop   = !redirect && !stall && !buf_empty;

    // -------------------------------------------------------------------------
    // Next-state: PC and counters
    // -------------------------------------------------------------------------
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = {redirect_addr[31:2], 2'b00};
        end else if (grant) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (grant) begin
            inflight_d = inflight_d + 1'b1;
        end
        if (imem_rvalid) begin
            inflight_d = inflight_d - 1'b1;
        end
    end

    // On redirect every request still outstanding after this cycle's response
    // is wrong-path; a response arriving in the redirect cycle is already
    // accounted for by inflight_d.
    always_comb begin
        kill_d = kill_q;
        if (redirect) begin
            kill_d = inflight_d;
        end else if (resp_kill) begin
            kill_d = kill_q - 1'b1;
        end
    end

    always_comb begin
        count_d  = count_q;
        buf_wr_d = buf_wr_q;
        buf_rd_d = buf_rd_q;
        if (redirect) begin
            count_d  = '0;
            buf_wr_d = '0;
            buf_rd_d = '0;
        end else begin
            if (buf_push) begin
                buf_wr_d = ptr_inc(buf_wr_q);
            end
            if (buf_pop) begin
                buf_rd_d = ptr_inc(buf_rd_q);
            end
            unique case ({buf_push, buf_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Next-state: output registers
    // -------------------------------------------------------------------------
    always_comb begin
        instr_d = instr_q;
        faddr_d = faddr_q;
        fplus_d = fplus_q;
        valid_d = valid_q;
        if (redirect) begin
            // Squash regardless of stall; the address outputs keep their value.
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (!stall) begin
            if (buf_pop) begin
                instr_d = buf_data[buf_rd_q];
                faddr_d = buf_addr[buf_rd_q];
                fplus_d = buf_addr[buf_rd_q] + 32'd4;
                valid_d = 1'b1;
            end else if (bypass) begin
                instr_d = imem_rdata;
                faddr_d = resp_addr;
                fplus_d = resp_addr + 32'd4;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP;
                valid_d = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            kill_q     <= '0;
            count_q    <= '0;
            aq_wr_q    <= '0;
            aq_rd_q    <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
            instr_q    <= NOP;
            faddr_q    <= 32'h0000_0000;
            fplus_q    <= 32'h0000_0004;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            count_q    <= count_d;
            buf_wr_q   <= buf_wr_d;
            buf_rd_q   <= buf_rd_d;
            instr_q    <= instr_d;
            faddr_q    <= faddr_d;
            fplus_q    <= fplus_d;
            valid_q    <= valid_d;
            // The address queue is never flushed: killed responses still pop it,
            // which keeps it aligned with the in-order response stream.
            if (grant) begin
                aq_wr_q <= ptr_inc(aq_wr_q);
            end
            if (imem_rvalid) begin
                aq_rd_q <= ptr_inc(aq_rd_q);
            end
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (!rst && grant) begin
            aq_mem[aq_wr_q] <= pc_q;
        end
        if (!rst && buf_push) begin
            buf_addr[buf_wr_q] <= resp_addr;
            buf_data[buf_wr_q] <= imem_rdata;
        end
    end

    assign instr                 = instr_q;
    assign fetch_instr_addr      = faddr_q;
    assign fetch_instr_addr_plus = fplus_q;
    assign fetch_valid           = valid_q;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    a_kill_le_inflight : assert property (@(posedge clk) disable iff (rst)
        kill_q <= inflight_q);
    a_credit_bound : assert property (@(posedge clk) disable iff (rst)
        credits_used <= {1'b0, DEPTH_C});
    a_no_orphan_resp : assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && inflight_q == '0));
    a_addr_aligned : assert property (@(posedge clk) disable iff (rst)
        imem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_stage_fetch.sv
module tb_stage_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0080;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] fetch_instr_addr;
    logic [31:0] fetch_instr_addr_plus;
    logic        fetch_valid;

    stage_fetch #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .imem_req              (imem_req),
        .imem_addr             (imem_addr),
        .imem_gnt              (imem_gnt),
        .imem_rvalid           (imem_rvalid),
        .imem_rdata            (imem_rdata),
        .redirect              (redirect),
        .redirect_addr         (redirect_addr),
        .stall                 (stall),
        .instr                 (instr),
        .fetch_instr_addr      (fetch_instr_addr),
        .fetch_instr_addr_plus (fetch_instr_addr_plus),
        .fetch_valid           (fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_A5A5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic apply(input logic r, input logic s, input logic rd, input logic [31:0] ra,
                         input logic g, input logic rv, input logic [31:0] rdt);
        @(negedge clk);
        rst           = r;
        stall         = s;
        redirect      = rd;
        redirect_addr = ra;
        imem_gnt      = g;
        imem_rvalid   = rv;
        imem_rdata    = rdt;
        #1;
    endtask

    task automatic chk_req(input string tag, input logic er, input logic [31:0] ea);
        chk({tag, " imem_req"}, 32'(imem_req), 32'(er));
        if (er) chk({tag, " imem_addr"}, imem_addr, ea);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ei, input logic [31:0] ef,
                           input logic ev);
        chk({tag, " instr"}, instr, ei);
        chk({tag, " fetch_instr_addr"}, fetch_instr_addr, ef);
        chk({tag, " fetch_instr_addr_plus"}, fetch_instr_addr_plus, ef + 32'd4);
        chk({tag, " fetch_valid"}, 32'(fetch_valid), 32'(ev));
    endtask

    // ------------------------------------------------------------------
    // Directed vectors: per cycle inputs, expected req/addr this cycle and
    // expected registered outputs after the clock edge.
    // ------------------------------------------------------------------
    typedef struct {
        logic        rst, stall, redir;
        logic [31:0] raddr;
        logic        gnt, rvalid;
        logic [31:0] rdata;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] efaddr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] ra,
                       input logic g, input logic rv, input logic [31:0] rd_a,
                       input logic er, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ef);
        vec_t v;
        v.rst = r; v.stall = s; v.redir = rd; v.raddr = ra; v.gnt = g; v.rvalid = rv;
        v.rdata = rv ? word(rd_a) : 32'h0;
        v.ereq = er; v.eaddr = ea; v.evalid = ev; v.efaddr = ef;
        vecs.push_back(v);
    endtask

    // ------------------------------------------------------------------
    // Reference model: queues of outstanding and returned words.
    // ------------------------------------------------------------------
    logic [31:0] m_pc;
    logic [31:0] m_infl[$];
    int          m_kill;
    logic [31:0] m_ba[$];
    logic [31:0] m_bd[$];
    logic [31:0] m_instr, m_faddr;
    logic        m_valid;
    logic [31:0] mem_a[$];
    int          mem_t[$];

    task automatic m_reset();
        m_pc = RST_PC; m_infl.delete(); m_kill = 0; m_ba.delete(); m_bd.delete();
        m_instr = NOP; m_faddr = 32'h0; m_valid = 1'b0;
        mem_a.delete(); mem_t.delete();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

        //   rst stl red raddr         gnt rv  rdata_a       ereq eaddr         ev  efaddr
        // Reset for three cycles.
        add(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
        // Streaming with a one-cycle memory.
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h80,       0, 32'h0);
        add(0, 0, 0, 32'h0,        1, 1, 32'h80,       1, 32'h84,       1, 32'h80);
        add(0, 0, 0, 32'h0,        1, 1, 32'h84,       1, 32'h88,       1, 32'h84);
        // Stall for five cycles: words buffer, req drops once credits are used.
        add(0, 1, 0, 32'h0,        1, 1, 32'h88,       1, 32'h8C,       1, 32'h84);
        add(0, 1, 0, 32'h0,        1, 1, 32'h8C,       0, 32'h0,        1, 32'h84);
        add(0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h84);
        add(0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h84);
        add(0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h84);
        // Release: buffered words drain in order, then streaming resumes.
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h88);
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h90,       1, 32'h8C);
        add(0, 0, 0, 32'h0,        1, 1, 32'h90,       1, 32'h94,       1, 32'h90);
        // Redirect with one word in flight.
        add(0, 0, 1, 32'h103,      1, 0, 32'h0,        0, 32'h0,        0, 32'h90);
        add(0, 0, 0, 32'h0,        0, 1, 32'h94,       1, 32'h100,      0, 32'h90);
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100,      0, 32'h90);
        add(0, 0, 0, 32'h0,        0, 1, 32'h100,      1, 32'h104,      1, 32'h100);
        add(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h104,      0, 32'h100);
        // Redirect with two words in flight.
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h104,      0, 32'h100);
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h108,      0, 32'h100);
        add(0, 0, 1, 32'h203,      1, 0, 32'h0,        0, 32'h0,        0, 32'h100);
        add(0, 0, 0, 32'h0,        1, 1, 32'h104,      0, 32'h0,        0, 32'h100);
        add(0, 0, 0, 32'h0,        1, 1, 32'h108,      1, 32'h200,      0, 32'h100);
        add(0, 0, 0, 32'h0,        0, 1, 32'h200,      1, 32'h204,      1, 32'h200);
        // Redirect during stall with a buffered word and a response arriving.
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h204,      0, 32'h200);
        add(0, 1, 0, 32'h0,        1, 1, 32'h204,      1, 32'h208,      0, 32'h200);
        add(0, 1, 1, 32'h400,      1, 1, 32'h208,      0, 32'h0,        0, 32'h200);
        add(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h400,      0, 32'h200);
        // Address wrap at 2^32.
        add(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0,       0, 32'h0,        0, 32'h200);
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h200);
        add(0, 0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 1, 32'h0,       1, 32'hFFFF_FFFC);
        add(0, 0, 0, 32'h0,        0, 1, 32'h0,        1, 32'h4,        1, 32'h0);
        // Reset mid-operation.
        add(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0);

        foreach (vecs[i]) begin
            vec_t v;
            string tag;
            v   = vecs[i];
            tag = $sformatf("vec%0d", i);
            apply(v.rst, v.stall, v.redir, v.raddr, v.gnt, v.rvalid, v.rdata);
            chk_req(tag, v.ereq, v.eaddr);
            @(posedge clk); #1;
            chk_out(tag, v.evalid ? word(v.efaddr) : NOP, v.efaddr, v.evalid);
        end

        // ------------------------------------------------------------------
        // Randomized traffic against the queue model; DUT is in reset here.
        // ------------------------------------------------------------------
        m_reset();
        for (int c = 0; c < 4000; c++) begin
            logic        r, s, rd, g, rv, er, got;
            logic [31:0] ra, rdt, g_addr, g_data;
            string       tag;
            tag = $sformatf("rnd%0d", c);
            r   = ($urandom_range(0, 499) == 0);
            s   = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 24) == 0);
            ra  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                              : $urandom;
            g   = ($urandom_range(0, 9) < 7);
            rv  = !r && (mem_a.size() > 0) && (mem_t[0] <= c) && ($urandom_range(0, 3) != 0);
            rdt = rv ? word(mem_a[0]) : $urandom;
            er  = !r && !rd && (m_infl.size() + m_ba.size() < DEPTH);

            apply(r, s, rd, ra, g, rv, rdt);
            chk_req(tag, er, m_pc);

            if (r) begin
                m_reset();
            end else begin
                got = 1'b0;
                g_addr = '0;
                g_data = '0;
                if (rv) begin
                    void'(mem_a.pop_front());
                    void'(mem_t.pop_front());
                    g_addr = m_infl.pop_front();
                    g_data = rdt;
                    if (m_kill > 0) m_kill--;
                    else got = 1'b1;
                end
                if (er && g) begin
                    mem_a.push_back(m_pc);
                    mem_t.push_back(c + 1 + int'($urandom_range(0, 2)));
                    m_infl.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
                if (rd) begin
                    m_pc = {ra[31:2], 2'b00};
                    m_ba.delete();
                    m_bd.delete();
                    m_kill  = m_infl.size();
                    m_instr = NOP;
                    m_valid = 1'b0;
                end else begin
                    if (got) begin
                        m_ba.push_back(g_addr);
                        m_bd.push_back(g_data);
                    end
                    if (!s) begin
                        if (m_ba.size() > 0) begin
                            m_faddr = m_ba.pop_front();
                            m_instr = m_bd.pop_front();
                            m_valid = 1'b1;
                        end else begin
                            m_instr = NOP;
                            m_valid = 1'b0;
                        end
                    end
                end
            end

            @(posedge clk); #1;
            chk_out(tag, m_instr, m_faddr, m_valid);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
